// File: rtl/rand_seq_buffer_if.sv
// rand_seq_buffer_if: playback symbol stream towards the game FSM.
// Valid/ready handshake carrying one symbol plus an end-of-sequence flag.
interface rand_seq_buffer_if #(
   parameter int SYM_BITS = 2
);
   logic                sym_valid;
   logic                sym_ready;
   logic [SYM_BITS-1:0] sym_out;
   logic                sym_last;

   modport master (
      output sym_valid,
      output sym_out,
      output sym_last,
      input  sym_ready
   );

   modport slave (
      input  sym_valid,
      input  sym_out,
      input  sym_last,
      output sym_ready
   );
endinterface

// File: rtl/rand_seq_buffer.sv
// rand_seq_buffer: samples an upstream LFSR into a symbol sequence and replays it.
// Optional macro RAND_SEQ_NO_REPEAT_EN drops adjacent repeated symbols during fill.
module rand_seq_buffer #(
   parameter  int DEPTH    = 16,
   parameter  int SYM_BITS = 2,
   localparam int PW       = $clog2(DEPTH),
   localparam int LW       = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           lfsr_in,
   input  logic                 lfsr_wrap_in,
   output logic                 lfsr_ce_out,
   input  logic                 gen_start,
   input  logic [LW-1:0]        gen_len,
   input  logic                 play_start,
   rand_seq_buffer_if.master    sym_if,
   output logic [LW-1:0]        seq_len,
   output logic                 seq_ready,
   output logic                 busy,
   output logic [7:0]           wrap_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_READY,
      S_PLAY
   } state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       len_q, len_d;
   logic [LW-1:0]       seq_len_q, seq_len_d;
   logic                seq_ready_q, seq_ready_d;
   logic [7:0]          wrap_cnt_q, wrap_cnt_d;
   logic [SYM_BITS-1:0] mem_q [DEPTH];

   logic [SYM_BITS-1:0] sym_new;
   logic [LW-1:0]       gen_clamped;
   logic                gen_ok;
   logic                gen_take;
   logic                wr_en;
   logic                wr_last;
   logic                rd_fire;
   logic                rd_last;
   logic                lfsr_unused;

   // Fold the top and bottom LFSR bits so both ends of the register matter
   assign sym_new     = lfsr_in[SYM_BITS-1:0] ^ lfsr_in[7:8-SYM_BITS];
   assign lfsr_unused = ^lfsr_in;

   assign gen_ok      = gen_start && (gen_len != '0);
   assign gen_take    = gen_ok && ((state_q == S_IDLE) || (state_q == S_READY));
   assign gen_clamped = (gen_len > LW'(DEPTH)) ? LW'(DEPTH) : gen_len;

`ifdef RAND_SEQ_NO_REPEAT_EN
   logic [SYM_BITS-1:0] prev_sym_q;

   // First write of a fill always lands; later ones must differ from the last
   assign wr_en = (state_q == S_FILL) &&
                  ((wr_ptr_q == '0) || (sym_new != prev_sym_q));

   // Remember the most recently stored symbol for repeat suppression
   always_ff @(posedge clk) begin
      if (wr_en) begin
         prev_sym_q <= sym_new;
      end
   end
`else
   assign wr_en = (state_q == S_FILL);
`endif

   assign wr_last = wr_en && ({1'b0, wr_ptr_q} == (len_q - LW'(1)));
   assign rd_fire = (state_q == S_PLAY) && sym_if.sym_ready;
   assign rd_last = ({1'b0, rd_ptr_q} == (seq_len_q - LW'(1)));

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a new fill beats a replay request in READY
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (gen_ok) begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (wr_last) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (gen_ok) begin
               state_d = S_FILL;
            end else if (play_start) begin
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (rd_fire && rd_last) begin
               state_d = S_READY;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath next-state: pointers, lengths, status and wrap counter
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      seq_len_d   = seq_len_q;
      seq_ready_d = seq_ready_q;
      wrap_cnt_d  = wrap_cnt_q;

      if (lfsr_wrap_in && (wrap_cnt_q != 8'hFF)) begin
         wrap_cnt_d = wrap_cnt_q + 8'd1;
      end

      if (gen_take) begin
         len_d       = gen_clamped;
         wr_ptr_d    = '0;
         seq_ready_d = 1'b0;
      end

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (wr_last) begin
         seq_len_d   = len_q;
         seq_ready_d = 1'b1;
      end

      if ((state_q == S_READY) && play_start && !gen_ok) begin
         rd_ptr_d = '0;
      end

      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         seq_len_q   <= '0;
         seq_ready_q <= 1'b0;
         wrap_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         seq_len_q   <= seq_len_d;
         seq_ready_q <= seq_ready_d;
         wrap_cnt_q  <= wrap_cnt_d;
      end
   end

   // Symbol store; contents are meaningless until a fill completes
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= sym_new;
      end
   end

   // Outputs decoded from state; stream fields are zero outside PLAY
   always_comb begin
      lfsr_ce_out      = (state_q == S_FILL);
      busy             = (state_q == S_FILL) || (state_q == S_PLAY);
      sym_if.sym_valid = (state_q == S_PLAY);
      sym_if.sym_out   = '0;
      sym_if.sym_last  = 1'b0;
      if (state_q == S_PLAY) begin
         sym_if.sym_out  = mem_q[rd_ptr_q];
         sym_if.sym_last = rd_last;
      end
   end

   assign seq_len   = seq_len_q;
   assign seq_ready = seq_ready_q;
   assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_rand_seq_buffer.sv
// tb_rand_seq_buffer: scenario tasks with a symbol scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rand_seq_buffer;
   localparam int DEPTH    = 16;
   localparam int SYM_BITS = 2;
   localparam int LW       = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    lfsr_in;
   logic          lfsr_wrap_in;
   logic          lfsr_ce_out;
   logic          gen_start;
   logic [LW-1:0] gen_len;
   logic          play_start;
   logic [LW-1:0] seq_len;
   logic          seq_ready;
   logic          busy;
   logic [7:0]    wrap_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [1:0] seq_ref[$];
   logic [1:0] exp_q[$];
   logic [1:0] obs_sym[$];
   logic       obs_last[$];
   int         hold_err;
   int         play_timeout;

   rand_seq_buffer_if #(.SYM_BITS(SYM_BITS)) sym_if ();

   rand_seq_buffer #(
      .DEPTH    (DEPTH),
      .SYM_BITS (SYM_BITS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lfsr_in      (lfsr_in),
      .lfsr_wrap_in (lfsr_wrap_in),
      .lfsr_ce_out  (lfsr_ce_out),
      .gen_start    (gen_start),
      .gen_len      (gen_len),
      .play_start   (play_start),
      .sym_if       (sym_if),
      .seq_len      (seq_len),
      .seq_ready    (seq_ready),
      .busy         (busy),
      .wrap_cnt     (wrap_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pulse gen_start, then feed vals while lfsr_ce_out stays high
   task automatic do_fill(input logic [LW-1:0] glen, input logic [7:0] vals[$],
                          output int ce_cycles);
      @(negedge clk);
      gen_start = 1'b1;
      gen_len   = glen;
      @(negedge clk);
      gen_start = 1'b0;
      gen_len   = '0;
      ce_cycles = 0;
      for (int i = 0; i < 100 && lfsr_ce_out; i++) begin
         lfsr_in = (ce_cycles < vals.size()) ? vals[ce_cycles] : 8'h00;
         ce_cycles++;
         @(negedge clk);
      end
      lfsr_in = 8'h00;
   endtask

   // Pulse play_start and collect handshaken symbols; mode 1 = 1,0,0 ready
   task automatic do_play(input int mode);
      logic [1:0] held_s;
      logic       held_l;
      logic       held_v;
      obs_sym.delete();
      obs_last.delete();
      hold_err     = 0;
      play_timeout = 1;
      held_v       = 1'b0;
      held_s       = '0;
      held_l       = 1'b0;
      @(negedge clk);
      play_start = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (held_v && (sym_if.sym_out !== held_s || sym_if.sym_last !== held_l))
            hold_err++;
         sym_if.sym_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         held_v = 1'b0;
         if (sym_if.sym_valid === 1'b1) begin
            if (sym_if.sym_ready) begin
               obs_sym.push_back(sym_if.sym_out);
               obs_last.push_back(sym_if.sym_last);
               if (sym_if.sym_last === 1'b1) begin
                  play_timeout = 0;
                  @(negedge clk);
                  break;
               end
            end else begin
               held_v = 1'b1;
               held_s = sym_if.sym_out;
               held_l = sym_if.sym_last;
            end
         end
         @(negedge clk);
      end
      sym_if.sym_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({lfsr_ce_out, sym_if.sym_valid, sym_if.sym_out, sym_if.sym_last,
           seq_len, seq_ready, busy, wrap_cnt} !== 20'h0)
         $display("FAIL reset_outputs: got ce=%b v=%b s=%0d l=%b len=%0d rdy=%b busy=%b wc=%0d required all 0",
                  lfsr_ce_out, sym_if.sym_valid, sym_if.sym_out, sym_if.sym_last,
                  seq_len, seq_ready, busy, wrap_cnt);
      else pass_cnt++;
      reset = 1'b1;
   endtask

   task automatic test_zero_len;
      logic [7:0] vals[$];
      int ce;
      vals = {8'h11, 8'h22};
      do_fill(5'd0, vals, ce);
      total_cnt++;
      if (ce !== 0) $display("FAIL zero_len_ce: got %0d cycles required 0", ce);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || seq_ready !== 1'b0)
         $display("FAIL zero_len_idle: got busy=%b rdy=%b required 0 0", busy, seq_ready);
      else pass_cnt++;
   endtask

   task automatic test_basic_fill;
      logic [7:0] vals[$];
      int ce;
      int exp_ce;
`ifdef RAND_SEQ_NO_REPEAT_EN
      vals    = {8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
      seq_ref = {2'd0, 2'd1, 2'd3, 2'd2};
      exp_ce  = 6;
`else
      vals    = {8'h00, 8'h01, 8'h03, 8'h07};
      seq_ref = {2'd0, 2'd1, 2'd3, 2'd3};
      exp_ce  = 4;
`endif
      do_fill(5'd4, vals, ce);
      total_cnt++;
      if (ce !== exp_ce) $display("FAIL basic_ce_cycles: got %0d required %0d", ce, exp_ce);
      else pass_cnt++;
      total_cnt++;
      if (seq_ready !== 1'b1 || seq_len !== 5'd4)
         $display("FAIL basic_status: got rdy=%b len=%0d required 1 4", seq_ready, seq_len);
      else pass_cnt++;
      exp_q = seq_ref;
      do_play(0);
      total_cnt++;
      if (play_timeout != 0 || obs_sym.size() != 4)
         $display("FAIL basic_play_count: got %0d symbols timeout=%0d required 4 0",
                  obs_sym.size(), play_timeout);
      else pass_cnt++;
      for (int i = 0; i < obs_sym.size() && exp_q.size() > 0; i++) begin
         logic [1:0] e;
         e = exp_q.pop_front();
         total_cnt++;
         if (obs_sym[i] !== e || obs_last[i] !== (i == 3))
            $display("FAIL basic_sym%0d: got %0d last=%b required %0d last=%b",
                     i, obs_sym[i], obs_last[i], e, (i == 3));
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure;
      for (int r = 0; r < 2; r++) begin
         exp_q = seq_ref;
         do_play(r == 0 ? 1 : 0);
         total_cnt++;
         if (play_timeout != 0 || obs_sym.size() != 4 || hold_err != 0)
            $display("FAIL bp_run%0d: got %0d symbols timeout=%0d hold_err=%0d required 4 0 0",
                     r, obs_sym.size(), play_timeout, hold_err);
         else pass_cnt++;
         for (int i = 0; i < obs_sym.size() && exp_q.size() > 0; i++) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_sym[i] !== e || obs_last[i] !== (i == 3))
               $display("FAIL bp_run%0d_sym%0d: got %0d last=%b required %0d last=%b",
                        r, i, obs_sym[i], obs_last[i], e, (i == 3));
            else pass_cnt++;
         end
         total_cnt++;
         if (seq_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_run%0d_retained: got rdy=%b busy=%b required 1 0", r, seq_ready, busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_clamp;
      logic [7:0] vals[$];
      logic [1:0] s;
      logic [1:0] prev;
      int ce;
      int used;
      int n;
      used = 0;
      n    = 0;
      prev = '0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) vals.push_back(8'($urandom));
      for (int i = 0; i < 64 && n < 16; i++) begin
         s = vals[i][1:0] ^ vals[i][7:6];
         used++;
`ifdef RAND_SEQ_NO_REPEAT_EN
         if (n > 0 && s == prev) continue;
`endif
         exp_q.push_back(s);
         prev = s;
         n++;
      end
      do_fill(5'd31, vals, ce);
      total_cnt++;
      if (ce !== used) $display("FAIL clamp_ce_cycles: got %0d required %0d", ce, used);
      else pass_cnt++;
      total_cnt++;
      if (seq_len !== 5'd16 || seq_ready !== 1'b1)
         $display("FAIL clamp_seq_len: got len=%0d rdy=%b required 16 1", seq_len, seq_ready);
      else pass_cnt++;
      do_play(0);
      total_cnt++;
      if (play_timeout != 0 || obs_sym.size() != 16)
         $display("FAIL clamp_play_count: got %0d timeout=%0d required 16 0",
                  obs_sym.size(), play_timeout);
      else pass_cnt++;
      for (int i = 0; i < obs_sym.size() && exp_q.size() > 0; i++) begin
         logic [1:0] e;
         e = exp_q.pop_front();
         total_cnt++;
         if (obs_sym[i] !== e || obs_last[i] !== (i == 15))
            $display("FAIL clamp_sym%0d: got %0d last=%b required %0d last=%b",
                     i, obs_sym[i], obs_last[i], e, (i == 15));
         else pass_cnt++;
      end
   endtask

   task automatic test_priority;
      int ce;
      @(negedge clk);
      gen_start  = 1'b1;
      play_start = 1'b1;
      gen_len    = 5'd2;
      @(negedge clk);
      gen_start  = 1'b0;
      play_start = 1'b0;
      gen_len    = '0;
      total_cnt++;
      if (lfsr_ce_out !== 1'b1 || sym_if.sym_valid !== 1'b0 || seq_ready !== 1'b0)
         $display("FAIL prio_fill_wins: got ce=%b v=%b rdy=%b required 1 0 0",
                  lfsr_ce_out, sym_if.sym_valid, seq_ready);
      else pass_cnt++;
      exp_q = {2'd1, 2'd3};
      ce = 0;
      for (int i = 0; i < 20 && lfsr_ce_out; i++) begin
         lfsr_in = (ce == 0) ? 8'h40 : 8'h81;
         ce++;
         @(negedge clk);
      end
      lfsr_in = 8'h00;
      total_cnt++;
      if (ce !== 2 || seq_len !== 5'd2)
         $display("FAIL prio_fill_len: got ce=%0d len=%0d required 2 2", ce, seq_len);
      else pass_cnt++;
      do_play(0);
      for (int i = 0; i < obs_sym.size() && exp_q.size() > 0; i++) begin
         logic [1:0] e;
         e = exp_q.pop_front();
         total_cnt++;
         if (obs_sym[i] !== e || obs_last[i] !== (i == 1))
            $display("FAIL prio_sym%0d: got %0d last=%b required %0d last=%b",
                     i, obs_sym[i], obs_last[i], e, (i == 1));
         else pass_cnt++;
      end
      total_cnt++;
      if (exp_q.size() != 0 || play_timeout != 0)
         $display("FAIL prio_play_count: got %0d leftover timeout=%0d required 0 0",
                  exp_q.size(), play_timeout);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      @(negedge clk);
      lfsr_wrap_in = 1'b1;
      repeat (5) @(negedge clk);
      lfsr_wrap_in = 1'b0;
      total_cnt++;
      if (wrap_cnt !== 8'd5) $display("FAIL wrap_count5: got %0d required 5", wrap_cnt);
      else pass_cnt++;
      lfsr_wrap_in = 1'b1;
      repeat (295) @(negedge clk);
      lfsr_wrap_in = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (wrap_cnt !== 8'd255) $display("FAIL wrap_saturate: got %0d required 255", wrap_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_midplay;
      @(negedge clk);
      sym_if.sym_ready = 1'b1;
      play_start       = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
      total_cnt++;
      if (sym_if.sym_valid !== 1'b1 || busy !== 1'b1)
         $display("FAIL midplay_active: got v=%b busy=%b required 1 1", sym_if.sym_valid, busy);
      else pass_cnt++;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset            = 1'b1;
      sym_if.sym_ready = 1'b0;
      total_cnt++;
      if ({lfsr_ce_out, sym_if.sym_valid, sym_if.sym_out, sym_if.sym_last,
           seq_len, seq_ready, busy, wrap_cnt} !== 20'h0)
         $display("FAIL midplay_reset_outputs: got ce=%b v=%b s=%0d l=%b len=%0d rdy=%b busy=%b wc=%0d required all 0",
                  lfsr_ce_out, sym_if.sym_valid, sym_if.sym_out, sym_if.sym_last,
                  seq_len, seq_ready, busy, wrap_cnt);
      else pass_cnt++;
      play_start = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (sym_if.sym_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL idle_play_ignored: got v=%b busy=%b required 0 0", sym_if.sym_valid, busy);
      else pass_cnt++;
   endtask

   initial begin
      reset            = 1'b0;
      lfsr_in          = 8'h00;
      lfsr_wrap_in     = 1'b0;
      gen_start        = 1'b0;
      gen_len          = '0;
      play_start       = 1'b0;
      sym_if.sym_ready = 1'b0;
      test_reset();
      test_zero_len();
      test_basic_fill();
      test_backpressure();
      test_clamp();
      test_priority();
      test_wrap();
      test_reset_midplay();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
